// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg
// Shared definitions for the hazard/forwarding/issue controller:
//   - forward-select encodings driven on ex_fwd_sel
//   - controller state codes (RUN / DRAIN / HALTED)
//   - the in-flight writer slot record kept for EX, MEM and WB
package pipeline_hazard_ctrl_pkg;

  // Slots store register addresses at a fixed width so the record can live
  // in the package; the controller zero-extends AW-bit addresses into it.
  // AW must not exceed SLOT_AW.
  localparam int SLOT_AW = 8;

  // Operand source selects, one 2-bit field per source operand.
  localparam logic [1:0] FWD_RF    = 2'b00;  // register file
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM result (ALU op one ahead)
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB result (load or ALU two ahead)
  localparam logic [1:0] FWD_WB    = 2'b11;  // write-back bypass (three ahead)

  // Controller states.
  typedef logic [1:0] state_t;
  localparam state_t ST_RUN    = 2'd0;
  localparam state_t ST_DRAIN  = 2'd1;
  localparam state_t ST_HALTED = 2'd2;

  // One in-flight instruction record.
  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               wr;
    logic               load;
  } slot_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
// Decode-side bundle between the decode stage (master) and the hazard
// controller (slave).
//   master drives : id_valid, id_rs, id_rs_used, id_rd, id_reg_write,
//                   id_is_load, id_is_halt, ex_redirect
//   slave drives  : stall, flush, issue, ex_fwd_sel, halted, stall_count,
//                   state_dbg (controller state, for observation)
//
// Handshake: id_valid is the offer of a decode instruction; issue is the
// acceptance. An instruction transfers into ID/EX on a rising edge exactly
// when issue=1 (which implies id_valid=1). While stall=1 the decode stage
// must hold its instruction stable; on flush=1 it is squashed instead.
interface pipeline_hazard_ctrl_if #(
  parameter int AW    = 3,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
);
  logic                 id_valid;
  logic [NSRC*AW-1:0]   id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic [AW-1:0]        id_rd;
  logic                 id_reg_write;
  logic                 id_is_load;
  logic                 id_is_halt;
  logic                 ex_redirect;
  logic                 stall;
  logic                 flush;
  logic                 issue;
  logic [NSRC*2-1:0]    ex_fwd_sel;
  logic                 halted;
  logic [CNT_W-1:0]     stall_count;
  logic [1:0]           state_dbg;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_is_load,
           id_is_halt, ex_redirect,
    input  stall, flush, issue, ex_fwd_sel, halted, stall_count, state_dbg
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_is_load,
           id_is_halt, ex_redirect,
    output stall, flush, issue, ex_fwd_sel, halted, stall_count, state_dbg
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// hazard_match
// Compares one source operand against the three in-flight writer slots and
// returns the forward select (youngest match wins) plus a load-use flag.
//   rs, used   : operand address and "operand is read" qualifier
//   s1, s2, s3 : EX, MEM, WB slot records
//   sel        : FWD_* encoding for this operand
//   load_use   : operand needs the result of a load still in EX
module hazard_match
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int AW       = 3,
  parameter int ZERO_REG = 0
) (
  input  logic [AW-1:0] rs,
  input  logic          used,
  input  slot_t         s1,
  input  slot_t         s2,
  input  slot_t         s3,
  output logic [1:0]    sel,
  output logic          load_use
);

  logic [SLOT_AW-1:0] rs_w;
  logic               rs_is_zero;
  logic               m1, m2, m3;

  assign rs_w       = SLOT_AW'(rs);
  // A hard-wired zero register always reads as zero, so it never forwards.
  assign rs_is_zero = (ZERO_REG != 0) && (rs == '0);

  assign m1 = s1.valid & s1.wr & used & (s1.rd == rs_w) & !rs_is_zero;
  assign m2 = s2.valid & s2.wr & used & (s2.rd == rs_w) & !rs_is_zero;
  assign m3 = s3.valid & s3.wr & used & (s3.rd == rs_w) & !rs_is_zero;

  // Once a load reaches MEM its data is on the MEM/WB path like any ALU
  // result, so the load kind of the older slots plays no part here.
  logic unused_older_load;
  assign unused_older_load = s2.load | s3.load;

  always_comb begin
    sel      = FWD_RF;
    load_use = 1'b0;
    if (m1) begin
      // A load in EX has no data yet: the select is moot because the
      // instruction is held back for a cycle.
      if (s1.load) load_use = 1'b1;
      else         sel      = FWD_EXMEM;
    end else if (m2) begin
      sel = FWD_MEMWB;
    end else if (m3) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard, forwarding and issue controller beside the decode stage of the
// 5-stage pipeline. Tracks in-flight writers in EX/MEM/WB slots, drives PC
// hold (stall), IF/ID squash (flush) and ID/EX acceptance (issue), registers
// per-operand forward selects for the instruction entering EX, drains the
// pipe after a halt and counts load-use stall cycles (saturating).
//   clk, rst : clock, synchronous active-high reset
//   bus      : decode-side bundle (slave modport), see pipeline_hazard_ctrl_if
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int AW       = 3,
  parameter int NSRC     = 2,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  slot_t              s1, s2, s3;
  slot_t              new_slot;
  state_t             state;
  logic [NSRC*2-1:0]  sel_all;
  logic [NSRC-1:0]    lu;
  logic [NSRC*2-1:0]  fwd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_run;
  logic               load_use;
  logic               stall;
  logic               flush;
  logic               issue;
  logic               cnt_inc;

  for (genvar i = 0; i < NSRC; i++) begin : g_op
    hazard_match #(
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_match (
      .rs       (bus.id_rs[i*AW +: AW]),
      .used     (bus.id_rs_used[i]),
      .s1       (s1),
      .s2       (s2),
      .s3       (s3),
      .sel      (sel_all[i*2 +: 2]),
      .load_use (lu[i])
    );
  end

  assign in_run   = (state == ST_RUN);
  // An empty decode slot is a bubble and can never cause a stall.
  assign load_use = bus.id_valid & (|lu);
  assign flush    = in_run & bus.ex_redirect;
  // Redirect beats load-use: the dependent instruction is squashed anyway.
  assign stall    = in_run ? (load_use & !bus.ex_redirect) : 1'b1;
  assign issue    = in_run & bus.id_valid & !stall & !bus.ex_redirect;
  assign cnt_inc  = in_run & load_use & !bus.ex_redirect;

  always_comb begin
    new_slot       = '0;
    new_slot.valid = 1'b1;
    new_slot.rd    = SLOT_AW'(bus.id_rd);
    new_slot.wr    = bus.id_reg_write;
    new_slot.load  = bus.id_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      fwd_q <= '0;
      cnt_q <= '0;
      state <= ST_RUN;
    end else begin
      s3    <= s2;
      s2    <= s1;
      s1    <= issue ? new_slot : '0;
      fwd_q <= issue ? sel_all : '0;
      if (cnt_inc && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      case (state)
        ST_RUN: begin
          if (issue && bus.id_is_halt) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Nothing issues after the halt, so once both younger slots are
          // bubbles the halt sits in WB and leaves on this edge.
          if (!s1.valid && !s2.valid) state <= ST_HALTED;
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

  assign bus.stall       = stall;
  assign bus.flush       = flush;
  assign bus.issue       = issue;
  assign bus.ex_fwd_sel  = fwd_q;
  assign bus.halted      = (state == ST_HALTED);
  assign bus.stall_count = cnt_q;
  assign bus.state_dbg   = state;

endmodule
